// File: rtl/wash_cycle.sv
// -----------------------------------------------------------------------------
// wash_cycle -- wash / rinse / spin sequencer stage of the washing machine.
//
// Runs the programme selected by `mode` through the phases with a nonzero
// duration, counting seconds down from a clk prescaler, with pause/resume.
// Once DONE, `next` tells the billing stage the cycle is complete. The stage
// is held in IDLE while `on` is low.
//
// Optional feature (macro WASH_OVERTIME_FINE_EN): while the machine sits in
// DONE the prescaler keeps running and counts seconds. After FINE_SEC seconds
// a sticky overtime fine is raised. Without the macro, `fine` and st_light[7]
// are tied low and the overtime counter does not exist.
//
// Parameters
//   TICK_DIV   clk cycles per one-second tick
//   FINE_SEC   seconds in DONE before the overtime fine asserts
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   on         stage enable; low forces IDLE and clears all outputs
//   mode       programme: 0 spin-only, 1 small, 2 medium, 3 large
//   start_pos  one-cycle start pulse (used only in IDLE)
//   pause_pos  one-cycle pause/resume pulse (used only in WASH/RINSE/SPIN)
//   phase      0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE
//   rem_sec    seconds remaining in the current phase
//   st_light   bit0 WASH, bit1 RINSE, bit2 SPIN, bit3 DONE, bit4 paused, bit7 fine
//   next       high while in DONE
//   fine       overtime fine flag
// -----------------------------------------------------------------------------
module wash_cycle #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned FINE_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic [1:0] mode,
    input  logic       start_pos,
    input  logic       pause_pos,
    output logic [2:0] phase,
    output logic [7:0] rem_sec,
    output logic [7:0] st_light,
    output logic       next,
    output logic       fine
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WASH  = 3'd1,
        RINSE = 3'd2,
        SPIN  = 3'd3,
        DONE  = 3'd4
    } phase_t;

    localparam int unsigned PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);

    if (TICK_DIV == 0 || FINE_SEC == 0) begin : g_bad_params
        $error("wash_cycle: TICK_DIV and FINE_SEC must be nonzero");
    end

    // Phase durations in seconds; DONE/IDLE have none.
    function automatic logic [7:0] dur(input logic [1:0] m, input phase_t p);
        case (p)
            WASH:    case (m)
                         2'd0:    dur = 8'd0;
                         2'd1:    dur = 8'd10;
                         2'd2:    dur = 8'd15;
                         default: dur = 8'd20;
                     endcase
            RINSE:   case (m)
                         2'd0:    dur = 8'd0;
                         2'd1:    dur = 8'd5;
                         2'd2:    dur = 8'd8;
                         default: dur = 8'd10;
                     endcase
            SPIN:    dur = (m == 2'd0) ? 8'd10 : 8'd5;
            default: dur = 8'd0;
        endcase
    endfunction

    // First phase after p that has a nonzero duration (from IDLE: the first one).
    function automatic phase_t follow(input logic [1:0] m, input phase_t p);
        case (p)
            IDLE:    follow = (dur(m, WASH) != 8'd0)  ? WASH :
                              (dur(m, RINSE) != 8'd0) ? RINSE : SPIN;
            WASH:    follow = (dur(m, RINSE) != 8'd0) ? RINSE : SPIN;
            RINSE:   follow = SPIN;
            default: follow = DONE;
        endcase
    endfunction

    phase_t           state_q, state_d, adv_phase;
    logic [7:0]       rem_q, rem_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             paused_q, paused_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       st_light_d;
    logic             next_d;
    logic             fine_d;

`ifdef WASH_OVERTIME_FINE_EN
    localparam int unsigned OT_W = (FINE_SEC > 1) ? $clog2(FINE_SEC) : 1;
    logic [OT_W-1:0] ot_q, ot_d;
    logic            fine_q;
    assign fine = fine_q;
`else
    assign fine_d = 1'b0;
    assign fine   = 1'b0;
`endif

    assign adv_phase = follow(mode_q, state_q);

    // State register. Every output is registered from its *_d value so that
    // phase, rem_sec, st_light and next always change on the same edge.
    // NOTE: sequential state uses <= so all flops sample pre-edge values;
    // reset is asynchronous and clears every flop, including the latched mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= 8'd0;
            psc_q    <= '0;
            paused_q <= 1'b0;
            mode_q   <= 2'd0;
            st_light <= 8'h00;
            next     <= 1'b0;
`ifdef WASH_OVERTIME_FINE_EN
            ot_q     <= '0;
            fine_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            psc_q    <= psc_d;
            paused_q <= paused_d;
            mode_q   <= mode_d;
            st_light <= st_light_d;
            next     <= next_d;
`ifdef WASH_OVERTIME_FINE_EN
            ot_q     <= ot_d;
            fine_q   <= fine_d;
`endif
        end
    end

    assign phase   = state_q;
    assign rem_sec = rem_q;

    // Next-state logic. A pause pulse takes priority over a tick in the same
    // cycle, so the prescaler holds and the countdown cannot slip past it.
    // NOTE: every signal gets a hold default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        psc_d    = psc_q;
        paused_d = paused_q;
        mode_d   = mode_q;
`ifdef WASH_OVERTIME_FINE_EN
        ot_d     = ot_q;
        fine_d   = fine_q;
`endif
        if (!on) begin
            state_d  = IDLE;
            rem_d    = 8'd0;
            psc_d    = '0;
            paused_d = 1'b0;
`ifdef WASH_OVERTIME_FINE_EN
            ot_d     = '0;
            fine_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pos) begin
                        mode_d   = mode;
                        state_d  = follow(mode, IDLE);
                        rem_d    = dur(mode, follow(mode, IDLE));
                        psc_d    = '0;
                        paused_d = 1'b0;
                    end
                end
                WASH, RINSE, SPIN: begin
                    if (pause_pos) begin
                        paused_d = !paused_q;
                    end else if (!paused_q) begin
                        if (psc_q == PSC_MAX) begin
                            psc_d = '0;
                            if (rem_q == 8'd1) begin
                                // Load the next duration directly; DONE loads 0.
                                state_d  = adv_phase;
                                rem_d    = dur(mode_q, adv_phase);
                                paused_d = 1'b0;
                            end else begin
                                rem_d = rem_q - 8'd1;
                            end
                        end else begin
                            psc_d = psc_q + 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef WASH_OVERTIME_FINE_EN
                    // Counter parks at FINE_SEC-1; the fine then stays set.
                    if (psc_q == PSC_MAX) begin
                        psc_d = '0;
                        if (ot_q == OT_W'(FINE_SEC - 1)) fine_d = 1'b1;
                        else                             ot_d   = ot_q + 1'b1;
                    end else begin
                        psc_d = psc_q + 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode of the next state, registered alongside it.
    always_comb begin
        st_light_d    = 8'h00;
        st_light_d[0] = (state_d == WASH);
        st_light_d[1] = (state_d == RINSE);
        st_light_d[2] = (state_d == SPIN);
        st_light_d[3] = (state_d == DONE);
        st_light_d[4] = paused_d;
        st_light_d[7] = fine_d;
        next_d        = (state_d == DONE);
    end

endmodule
